spi_cmd_dispatcher: RTL and testbench

SPI_CMD_DISPATCHER -- requirements
Module: spi_cmd_dispatcher

---
 rtl/spi_cmd_pkg.sv | 7 +
 rtl/spi_frame_assembler.sv | 76 +++++++
 rtl/spi_cmd_dispatcher.sv | 107 ++++++++++
 tb/tb_spi_cmd_dispatcher.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared FSM state, channel-field position and error-code types for the SPI command dispatcher
package spi_cmd_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DISPATCH} state_t;
    localparam int CH_MSB = 7;
    localparam int CH_LSB = 4;
    typedef enum logic [2:0] {ERR_NONE, ERR_TIMEOUT, ERR_BAD_CHANNEL, ERR_CHECKSUM, ERR_OVERRUN} err_t;
endpackage

// File: rtl/spi_frame_assembler.sv
// spi_frame_assembler: collects instruction + payload bytes, tracks the inter-byte gap and the frame checksum
//   clk, rst_n       : clock and asynchronous active-low reset
//   state            : dispatcher FSM state; bytes are only taken in IDLE/COLLECT
//   spi_byte/_valid  : incoming byte strobe
//   instr, data      : captured instruction and payload (first byte in the MSBs)
//   last             : final byte of the frame is being accepted this cycle
//   timed_out        : gap limit reached this cycle with no byte arriving
//   csum_ok          : trailing checksum byte matches (always 1 unless SPI_CMD_CHECKSUM_EN)
// Optional feature macro: SPI_CMD_CHECKSUM_EN (adds one trailing XOR checksum byte per frame)
module spi_frame_assembler
    import spi_cmd_pkg::*;
#(
    parameter int DATA_BYTES     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  state_t                  state,
    input  logic [7:0]              spi_byte,
    input  logic                    spi_input_valid,
    output logic [7:0]              instr,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    last,
    output logic                    timed_out,
    output logic                    csum_ok
);
`ifdef SPI_CMD_CHECKSUM_EN
    localparam int TOTAL = DATA_BYTES + 1;
`else
    localparam int TOTAL = DATA_BYTES;
`endif
    localparam int DW = 8 * DATA_BYTES;
    localparam int GW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [3:0]    cnt;
    logic [GW-1:0] gap;
    logic          collecting;
    logic          start;
    assign collecting = state == COLLECT;
    assign start      = spi_input_valid && state == IDLE;
    assign last       = collecting && spi_input_valid && cnt == 4'(TOTAL - 1);
    // An arriving byte always beats an expiring gap counter.
    assign timed_out  = (TIMEOUT_CYCLES != 0) && collecting && !spi_input_valid && gap == GW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            data  <= '0;
            cnt   <= '0;
            gap   <= '0;
        end else if (start) begin
            instr <= spi_byte;
            cnt   <= '0;
            gap   <= '0;
        end else if (collecting) begin
            gap <= spi_input_valid ? '0 : gap + 1'b1;
            if (spi_input_valid) begin
                cnt <= cnt + 1'b1;
                if (cnt < 4'(DATA_BYTES))
                    data <= DW'({data, spi_byte});
            end
        end
    end
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= '0;
        else if (start)
            csum <= spi_byte;
        else if (collecting && spi_input_valid)
            csum <= csum ^ spi_byte;
    end
    assign csum_ok = csum == spi_byte;
`else
    assign csum_ok = 1'b1;
`endif
endmodule

// File: rtl/spi_cmd_dispatcher.sv
// spi_cmd_dispatcher: turns SPI byte frames into one-hot per-channel command handshakes
//   sysClk, sysRst_n        : clock, asynchronous active-low reset (release synchronised internally)
//   spi_byte, spi_input_valid : received byte strobe
//   cmd_instruction, cmd_data : pending frame, stable while cmd_valid is high
//   cmd_valid, cmd_ready    : one-hot command valid / per-channel consumer ready
//   busy                    : FSM not in IDLE
//   err_*                   : single-cycle error pulses
//   cmd_count               : completed handshakes, wrapping
// Optional feature macro: SPI_CMD_CHECKSUM_EN (trailing checksum byte, err_checksum live)
module spi_cmd_dispatcher
    import spi_cmd_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_BYTES     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    sysClk,
    input  logic                    sysRst_n,
    input  logic [7:0]              spi_byte,
    input  logic                    spi_input_valid,
    output logic [7:0]              cmd_instruction,
    output logic [8*DATA_BYTES-1:0] cmd_data,
    output logic [NUM_CH-1:0]       cmd_valid,
    input  logic [NUM_CH-1:0]       cmd_ready,
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_bad_channel,
    output logic                    err_overrun,
    output logic                    err_checksum,
    output logic [15:0]             cmd_count
);
    logic [1:0] rst_sync;
    logic       rst_n;
    state_t     state, state_nxt;
    err_t       err, err_nxt;
    logic       last, timed_out, csum_ok, ch_ok, hs;
    logic [3:0] ch;
    // Reset asserts immediately everywhere but releases two clocks later.
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];
    spi_frame_assembler #(
        .DATA_BYTES     (DATA_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_asm (
        .clk             (sysClk),
        .rst_n           (rst_n),
        .state           (state),
        .spi_byte        (spi_byte),
        .spi_input_valid (spi_input_valid),
        .instr           (cmd_instruction),
        .data            (cmd_data),
        .last            (last),
        .timed_out       (timed_out),
        .csum_ok         (csum_ok)
    );
    assign ch        = cmd_instruction[CH_MSB:CH_LSB];
    assign ch_ok     = 32'(ch) < NUM_CH;
    assign cmd_valid = (state == DISPATCH) ? NUM_CH'(1) << ch : '0;
    assign hs        = |(cmd_valid & cmd_ready);
    assign busy      = state != IDLE;
    always_comb begin
        state_nxt = state;
        err_nxt   = ERR_NONE;
        unique case (state)
            IDLE:     state_nxt = spi_input_valid ? COLLECT : IDLE;
            COLLECT: begin
                if (timed_out) begin
                    state_nxt = IDLE;
                    err_nxt   = ERR_TIMEOUT;
                end else if (last) begin
                    state_nxt = (ch_ok && csum_ok) ? DISPATCH : IDLE;
                    err_nxt   = !ch_ok ? ERR_BAD_CHANNEL : !csum_ok ? ERR_CHECKSUM : ERR_NONE;
                end
            end
            DISPATCH: begin
                state_nxt = hs ? IDLE : DISPATCH;
                err_nxt   = spi_input_valid ? ERR_OVERRUN : ERR_NONE;
            end
            default:  state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err       <= ERR_NONE;
            cmd_count <= '0;
        end else begin
            state     <= state_nxt;
            err       <= err_nxt;
            cmd_count <= cmd_count + 16'(hs);
        end
    end
    // A single registered error code keeps the pulses mutually exclusive.
    assign err_timeout     = err == ERR_TIMEOUT;
    assign err_bad_channel = err == ERR_BAD_CHANNEL;
    assign err_overrun     = err == ERR_OVERRUN;
`ifdef SPI_CMD_CHECKSUM_EN
    assign err_checksum    = err == ERR_CHECKSUM;
`else
    assign err_checksum    = 1'b0;
`endif
endmodule

// File: tb/tb_spi_cmd_dispatcher.sv
// tb_spi_cmd_dispatcher: scoreboard bench for spi_cmd_dispatcher (default parameters; honours SPI_CMD_CHECKSUM_EN)
module tb_spi_cmd_dispatcher;
    localparam int K_HS = 0, K_TO = 1, K_BAD = 2, K_CS = 3, K_OVR = 4;
    typedef struct {
        int          kind;
        logic [3:0]  valid;
        logic [7:0]  instr;
        logic [63:0] data;
    } exp_t;
    logic        sysClk = 1'b0;
    logic        sysRst_n = 1'b0;
    logic [7:0]  spi_byte = '0;
    logic        spi_input_valid = 1'b0;
    logic [7:0]  cmd_instruction;
    logic [63:0] cmd_data;
    logic [3:0]  cmd_valid;
    logic [3:0]  cmd_ready = '0;
    logic        busy, err_timeout, err_bad_channel, err_overrun, err_checksum;
    logic [15:0] cmd_count;
    exp_t        q[$];
    exp_t        mon_e;
    int          mon_k;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_cnt = 0;
    spi_cmd_dispatcher dut (
        .sysClk          (sysClk),
        .sysRst_n        (sysRst_n),
        .spi_byte        (spi_byte),
        .spi_input_valid (spi_input_valid),
        .cmd_instruction (cmd_instruction),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_bad_channel (err_bad_channel),
        .err_overrun     (err_overrun),
        .err_checksum    (err_checksum),
        .cmd_count       (cmd_count)
    );
    always #5 sysClk = ~sysClk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic push(input int k, input logic [3:0] v, input logic [7:0] i, input logic [63:0] d);
        exp_t e;
        e.kind = k; e.valid = v; e.instr = i; e.data = d;
        q.push_back(e);
        if (k == K_HS) exp_cnt++;
    endtask
    task automatic send_byte(input logic [7:0] b);
        spi_byte = b;
        spi_input_valid = 1'b1;
        @(posedge sysClk);
        #1 spi_input_valid = 1'b0;
    endtask
    task automatic send_tail(input logic [7:0] ins, input logic [63:0] d, input int from);
        for (int i = from; i < 8; i++) send_byte(d[63-8*i -: 8]);
`ifdef SPI_CMD_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = ins;
            for (int i = 0; i < 8; i++) cs ^= d[63-8*i -: 8];
            send_byte(cs);
        end
`endif
    endtask
    task automatic send_frame(input logic [7:0] ins, input logic [63:0] d);
        send_byte(ins);
        send_tail(ins, d, 0);
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge sysClk);
        #1;
    endtask
    task automatic check_zero(input string tag);
        chk({tag, "_instr"}, cmd_instruction, 0);
        chk({tag, "_data"}, cmd_data, 0);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_errs"}, {err_timeout, err_bad_channel, err_overrun, err_checksum}, 0);
        chk({tag, "_count"}, cmd_count, 0);
    endtask
    always @(negedge sysClk) begin
        if (sysRst_n) begin
            mon_k = err_timeout ? K_TO : err_bad_channel ? K_BAD : err_checksum ? K_CS :
                    err_overrun ? K_OVR : |(cmd_valid & cmd_ready) ? K_HS : -1;
            if (cmd_valid != 0) chk("valid_onehot", 64'($onehot0(cmd_valid)), 1);
            if (err_timeout | err_bad_channel | err_overrun | err_checksum)
                chk("err_exclusive", 64'($onehot({err_timeout, err_bad_channel, err_overrun, err_checksum})), 1);
            if (mon_k >= 0) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got kind %0d, expected none", mon_k);
                end else begin
                    mon_e = q.pop_front();
                    chk("event_kind", 64'(mon_k), 64'(mon_e.kind));
                    if (mon_e.kind == K_HS && mon_k == K_HS) begin
                        chk("hs_valid", cmd_valid, mon_e.valid);
                        chk("hs_instr", cmd_instruction, mon_e.instr);
                        chk("hs_data", cmd_data, mon_e.data);
                    end
                end
            end
        end
    end
    initial begin
        idle(3);
        check_zero("reset");
        sysRst_n = 1'b1;
        idle(4);
        // Basic frame on channel 2, ready everywhere.
        cmd_ready = 4'hF;
        push(K_HS, 4'b0100, 8'h21, 64'h0102030405060708);
        send_frame(8'h21, 64'h0102030405060708);
        @(negedge sysClk);
        chk("latency_valid", cmd_valid, 4'b0100);
        chk("latency_data", cmd_data, 64'h0102030405060708);
        idle(1);
        chk("post_hs_valid", cmd_valid, 0);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_count", cmd_count, 64'(exp_cnt));
        // Highest channel.
        push(K_HS, 4'b1000, 8'h3A, 64'hDEADBEEFCAFEF00D);
        send_frame(8'h3A, 64'hDEADBEEFCAFEF00D);
        idle(2);
        chk("ch3_count", cmd_count, 64'(exp_cnt));
        // Out-of-range channel.
        push(K_BAD, 0, 0, 0);
        send_frame(8'h51, 64'h1111111111111111);
        @(negedge sysClk);
        chk("bad_ch_pulse", err_bad_channel, 1);
        chk("bad_ch_valid", cmd_valid, 0);
        @(negedge sysClk);
        chk("bad_ch_once", err_bad_channel, 0);
        chk("bad_ch_busy", busy, 0);
        idle(1);
        // Gap timeout after a partial frame.
        push(K_TO, 0, 0, 0);
        send_byte(8'h10);
        for (int i = 1; i <= 3; i++) send_byte(8'(i));
        idle(1023);
        chk("busy_before_timeout", busy, 1);
        idle(1);
        chk("timeout_pulse", err_timeout, 1);
        chk("busy_after_timeout", busy, 0);
        push(K_HS, 4'b0001, 8'h05, 64'hA1A2A3A4A5A6A7A8);
        send_frame(8'h05, 64'hA1A2A3A4A5A6A7A8);
        idle(2);
        // A byte on the expiry cycle is kept.
        push(K_HS, 4'b0100, 8'h2F, 64'h0011223344556677);
        send_byte(8'h2F);
        send_byte(8'h00);
        send_byte(8'h11);
        idle(1022);
        #10;
        send_tail(8'h2F, 64'h0011223344556677, 2);
        idle(2);
        chk("byte_wins_count", cmd_count, 64'(exp_cnt));
        // Overrun while the consumer stalls.
        cmd_ready = 4'h0;
        send_frame(8'h0C, 64'h8877665544332211);
        push(K_OVR, 0, 0, 0);
        push(K_OVR, 0, 0, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cmd_ready = 4'b1110;
        idle(3);
        chk("stall_valid", cmd_valid, 4'b0001);
        chk("stall_data", cmd_data, 64'h8877665544332211);
        chk("stall_instr", cmd_instruction, 8'h0C);
        chk("stall_count", cmd_count, 64'(exp_cnt));
        push(K_HS, 4'b0001, 8'h0C, 64'h8877665544332211);
        cmd_ready = 4'b0001;
        idle(1);
        chk("release_valid", cmd_valid, 0);
        chk("release_count", cmd_count, 64'(exp_cnt));
        cmd_ready = 4'hF;
        idle(2);
        // Reset in the middle of collection.
        send_byte(8'h20);
        for (int i = 1; i <= 3; i++) send_byte(8'(8'h40 + i));
        #2 sysRst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_zero("reset_mid");
        idle(2);
        sysRst_n = 1'b1;
        idle(4);
        push(K_HS, 4'b1000, 8'h31, 64'h0F1E2D3C4B5A6978);
        send_frame(8'h31, 64'h0F1E2D3C4B5A6978);
        idle(2);
        chk("after_reset_count", cmd_count, 64'(exp_cnt));
`ifdef SPI_CMD_CHECKSUM_EN
        push(K_CS, 0, 0, 0);
        send_byte(8'h00);
        repeat (8) send_byte(8'h00);
        send_byte(8'h01);
        idle(2);
        chk("csum_bad_busy", busy, 0);
        push(K_HS, 4'b0001, 8'h00, 64'h0);
        send_frame(8'h00, 64'h0);
        idle(2);
        chk("csum_ok_count", cmd_count, 64'(exp_cnt));
`endif
        idle(5);
        chk("queue_drained", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
